// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the machine-mode interrupt controller: cause codes,
// mip bit positions, privilege encoding and the request FSM states.
package intr_ctrl_pkg;

   localparam logic [1:0] MODE_M = 2'b11;

   localparam int MIP_MSIP_BIT = 3;
   localparam int MIP_MTIP_BIT = 7;
   localparam int MIP_MEIP_BIT = 11;

   localparam logic [3:0] CODE_MSI = 4'd3;
   localparam logic [3:0] CODE_MTI = 4'd7;
   localparam logic [3:0] CODE_MEI = 4'd11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } irq_state_e;

   typedef struct packed {
      logic mei;
      logic msi;
      logic mti;
   } irq_src_t;

   // Interrupt mcause: MSB set, exception code in the low nibble.
   function automatic logic [63:0] irq_cause(input logic [3:0] code);
      return {1'b1, 59'd0, code};
   endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority interrupt source selector: MEI > MSI > MTI.
module irq_prio_enc
   import intr_ctrl_pkg::*;
(
   input  irq_src_t   pend,
   output logic       vld,
   output irq_src_t   sel,
   output logic [3:0] code
);

   always_comb begin
      vld  = |pend;
      sel  = '0;
      code = '0;
      if (pend.mei) begin
         sel.mei = 1'b1;
         code    = CODE_MEI;
      end else if (pend.msi) begin
         sel.msi = 1'b1;
         code    = CODE_MSI;
      end else if (pend.mti) begin
         sel.mti = 1'b1;
         code    = CODE_MTI;
      end
   end

endmodule

// File: rtl/intr_ctrl.sv
// Machine-mode interrupt controller: mtime/mtimecmp timer, msip, external line
// synchroniser and a request/ack handshake towards the commit stage.
module intr_ctrl
   import intr_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_ext_irq,
   input  logic        i_timer_tick,
   input  logic        i_cmp_wen,
   input  logic [63:0] i_cmp_val,
   input  logic        i_msip_wen,
   input  logic        i_msip_val,
   input  logic [1:0]  i_mode,
   input  logic        i_mstatus_mie,
   input  logic [63:0] i_mie,
   output logic [63:0] o_mip,
   output logic [63:0] o_mtime,
   output logic        o_irq_req,
   output logic [63:0] o_irq_cause,
   input  logic        i_irq_ack
);

   logic        ext_p0, ext_p1;
   logic [63:0] mtime_q;
   logic [63:0] mtimecmp_q;
   logic        mtip_p1;
   logic        msip_q;

   logic [63:0] mip;
   logic [63:0] candidate;
   irq_src_t    cand_src;
   irq_src_t    sel;
   irq_src_t    sel_q;
   logic        vld;
   logic [3:0]  code;
   logic        global_en;
   logic        still_pending;
   logic        latch;
   logic [63:0] cause_q;
   logic        unused_cand;

   irq_state_e  state, state_n;

   // Stage p0/p1: external line synchroniser; timer compare registered into p1.
   always_ff @(posedge clk) begin
      if (rst) begin
         ext_p0     <= 1'b0;
         ext_p1     <= 1'b0;
         mtime_q    <= '0;
         mtimecmp_q <= '1;
         mtip_p1    <= 1'b0;
         msip_q     <= 1'b0;
      end else begin
         ext_p0  <= i_ext_irq;
         ext_p1  <= ext_p0;
         if (i_timer_tick)
            mtime_q <= mtime_q + 64'd1;
         if (i_cmp_wen)
            mtimecmp_q <= i_cmp_val;
         // Compares against the pre-write mtimecmp when a write lands this cycle.
         mtip_p1 <= (mtime_q >= mtimecmp_q);
         if (i_msip_wen)
            msip_q <= i_msip_val;
      end
   end

   always_comb begin
      mip               = '0;
      mip[MIP_MEIP_BIT] = ext_p1;
      mip[MIP_MTIP_BIT] = mtip_p1;
      mip[MIP_MSIP_BIT] = msip_q;
   end

   assign candidate    = mip & i_mie;
   assign cand_src.mei = candidate[MIP_MEIP_BIT];
   assign cand_src.msi = candidate[MIP_MSIP_BIT];
   assign cand_src.mti = candidate[MIP_MTIP_BIT];
   assign unused_cand  = ^{candidate[63:12], candidate[10:8], candidate[6:4], candidate[2:0]};

   assign global_en     = (i_mode < MODE_M) | i_mstatus_mie;
   assign still_pending = |(sel_q & cand_src);

   irq_prio_enc u_prio (
      .pend (cand_src),
      .vld  (vld),
      .sel  (sel),
      .code (code)
   );

   always_comb begin
      state_n = state;
      latch   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (vld && global_en) begin
               latch   = 1'b1;
               state_n = ST_REQ;
            end
         end
         ST_REQ: begin
            // Ack wins over a withdrawal seen in the same cycle.
            if (i_irq_ack)
               state_n = ST_WAIT;
            else if (!still_pending || !global_en)
               state_n = ST_IDLE;
         end
         ST_WAIT: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         sel_q   <= '0;
         cause_q <= '0;
      end else begin
         state <= state_n;
         if (latch) begin
            sel_q   <= sel;
            cause_q <= irq_cause(code);
         end
      end
   end

   assign o_mip       = mip;
   assign o_mtime     = mtime_q;
   assign o_irq_req   = (state == ST_REQ);
   assign o_irq_cause = cause_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: a vector table for the external-interrupt handshake,
// then hand-written sequences for timer, priority, withdrawal, reset and wrap.
module tb_intr_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_ext_irq;
   logic        i_timer_tick;
   logic        i_cmp_wen;
   logic [63:0] i_cmp_val;
   logic        i_msip_wen;
   logic        i_msip_val;
   logic [1:0]  i_mode;
   logic        i_mstatus_mie;
   logic [63:0] i_mie;
   logic [63:0] o_mip;
   logic [63:0] o_mtime;
   logic        o_irq_req;
   logic [63:0] o_irq_cause;
   logic        i_irq_ack;

   intr_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .i_ext_irq     (i_ext_irq),
      .i_timer_tick  (i_timer_tick),
      .i_cmp_wen     (i_cmp_wen),
      .i_cmp_val     (i_cmp_val),
      .i_msip_wen    (i_msip_wen),
      .i_msip_val    (i_msip_val),
      .i_mode        (i_mode),
      .i_mstatus_mie (i_mstatus_mie),
      .i_mie         (i_mie),
      .o_mip         (o_mip),
      .o_mtime       (o_mtime),
      .o_irq_req     (o_irq_req),
      .o_irq_cause   (o_irq_cause),
      .i_irq_ack     (i_irq_ack)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        req;
      logic [63:0] cause;
      logic [63:0] mip;
   } exp_t;

   typedef struct {
      logic        rst;
      logic        ext;
      logic        ack;
      logic        smie;
      logic [1:0]  mode;
      logic [63:0] mie;
      logic        e_req;
      logic [3:0]  e_code;
      logic [63:0] e_mip;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[14];
   int   total = 0;
   int   bad   = 0;

   localparam logic [63:0] MIP_MEI = 64'h800;
   localparam logic [63:0] MIP_MTI = 64'h080;
   localparam logic [63:0] MIP_MSI = 64'h008;

   function automatic logic [63:0] cz(input logic [3:0] c);
      return (c == 4'd0) ? 64'd0 : {1'b1, 59'd0, c};
   endfunction

   function automatic vec_t mkv(input logic r, input logic x, input logic a, input logic s,
                                input logic [1:0] m, input logic [63:0] ie, input logic er,
                                input logic [3:0] ec, input logic [63:0] em);
      vec_t v;
      v.rst = r; v.ext = x; v.ack = a; v.smie = s; v.mode = m; v.mie = ie;
      v.e_req = er; v.e_code = ec; v.e_mip = em;
      return v;
   endfunction

   task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask

   // One clock: expectation queued at drive time, compared after the edge.
   task automatic cyc(input string nm, input logic e_req, input logic [3:0] e_code,
                      input logic [63:0] e_mip);
      exp_t e;
      exp_t g;
      e.name = nm; e.req = e_req; e.cause = cz(e_code); e.mip = e_mip;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         total++; bad++;
         $display("FAIL %s: scoreboard empty", nm);
      end else begin
         g = sb.pop_front();
         check64({g.name, " req"}, {63'd0, o_irq_req}, {63'd0, g.req});
         check64({g.name, " cause"}, o_irq_cause, g.cause);
         check64({g.name, " mip"}, o_mip, g.mip);
      end
   endtask

   initial begin
      rst = 1'b1; i_ext_irq = 1'b0; i_timer_tick = 1'b0; i_cmp_wen = 1'b0; i_cmp_val = '0;
      i_msip_wen = 1'b0; i_msip_val = 1'b0; i_mode = 2'd0; i_mstatus_mie = 1'b0;
      i_mie = '0; i_irq_ack = 1'b0;

      //             rst  ext  ack  smie mode   mie      req code   mip
      tbl[0]  = mkv(1'b1,1'b0,1'b0,1'b0,2'd3, 64'd0,   1'b0,4'd0, 64'd0);
      tbl[1]  = mkv(1'b0,1'b1,1'b0,1'b1,2'd3, MIP_MEI, 1'b0,4'd0, 64'd0);
      tbl[2]  = mkv(1'b0,1'b1,1'b0,1'b1,2'd3, MIP_MEI, 1'b0,4'd0, MIP_MEI);
      tbl[3]  = mkv(1'b0,1'b1,1'b0,1'b1,2'd3, MIP_MEI, 1'b1,4'd11,MIP_MEI);
      tbl[4]  = mkv(1'b0,1'b0,1'b1,1'b1,2'd3, MIP_MEI, 1'b0,4'd11,MIP_MEI);
      tbl[5]  = mkv(1'b0,1'b0,1'b0,1'b1,2'd3, MIP_MEI, 1'b0,4'd11,64'd0);
      tbl[6]  = mkv(1'b0,1'b0,1'b1,1'b1,2'd3, MIP_MEI, 1'b0,4'd11,64'd0);
      tbl[7]  = mkv(1'b0,1'b1,1'b0,1'b0,2'd3, MIP_MEI, 1'b0,4'd11,64'd0);
      tbl[8]  = mkv(1'b0,1'b1,1'b0,1'b0,2'd3, MIP_MEI, 1'b0,4'd11,MIP_MEI);
      tbl[9]  = mkv(1'b0,1'b1,1'b0,1'b0,2'd3, MIP_MEI, 1'b0,4'd11,MIP_MEI);
      tbl[10] = mkv(1'b0,1'b1,1'b0,1'b1,2'd3, MIP_MEI, 1'b1,4'd11,MIP_MEI);
      tbl[11] = mkv(1'b0,1'b1,1'b0,1'b0,2'd3, MIP_MEI, 1'b0,4'd11,MIP_MEI);
      tbl[12] = mkv(1'b0,1'b0,1'b0,1'b0,2'd3, MIP_MEI, 1'b0,4'd11,MIP_MEI);
      tbl[13] = mkv(1'b0,1'b0,1'b0,1'b0,2'd3, MIP_MEI, 1'b0,4'd11,64'd0);

      cyc("reset", 1'b0, 4'd0, 64'd0);
      check64("reset mtime", o_mtime, 64'd0);

      for (int i = 0; i < 14; i++) begin
         rst = tbl[i].rst; i_ext_irq = tbl[i].ext; i_irq_ack = tbl[i].ack;
         i_mstatus_mie = tbl[i].smie; i_mode = tbl[i].mode; i_mie = tbl[i].mie;
         cyc($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_code, tbl[i].e_mip);
      end
      rst = 1'b0; i_irq_ack = 1'b0; i_ext_irq = 1'b0;

      // Timer in U mode with mstatus.mie clear; cmp writes see the old value.
      i_mode = 2'd0; i_mstatus_mie = 1'b0; i_mie = '0;
      i_cmp_wen = 1'b1; i_cmp_val = 64'd0;
      cyc("cmp old ones", 1'b0, 4'd11, 64'd0);
      i_cmp_val = 64'd5;
      cyc("cmp old zero", 1'b0, 4'd11, MIP_MTI);
      i_cmp_wen = 1'b0;
      cyc("cmp new five", 1'b0, 4'd11, 64'd0);
      i_mie = MIP_MTI; i_timer_tick = 1'b1;
      for (int k = 1; k <= 5; k++) cyc($sformatf("tick%0d", k), 1'b0, 4'd11, 64'd0);
      check64("mtime after 5", o_mtime, 64'd5);
      i_timer_tick = 1'b0;
      cyc("mtip set", 1'b0, 4'd11, MIP_MTI);
      cyc("mti req", 1'b1, 4'd7, MIP_MTI);
      i_irq_ack = 1'b1; i_cmp_wen = 1'b1; i_cmp_val = '1;
      cyc("mti ack", 1'b0, 4'd7, MIP_MTI);
      i_irq_ack = 1'b0; i_cmp_wen = 1'b0;
      cyc("mti wait", 1'b0, 4'd7, 64'd0);
      cyc("mti idle", 1'b0, 4'd7, 64'd0);

      // All three pending and enabled, released together by mstatus.mie.
      i_mode = 2'd3; i_mie = MIP_MEI | MIP_MTI | MIP_MSI; i_ext_irq = 1'b1;
      i_msip_wen = 1'b1; i_msip_val = 1'b1; i_cmp_wen = 1'b1; i_cmp_val = 64'd0;
      cyc("prio e1", 1'b0, 4'd7, MIP_MSI);
      i_msip_wen = 1'b0; i_cmp_wen = 1'b0;
      cyc("prio e2", 1'b0, 4'd7, MIP_MEI | MIP_MTI | MIP_MSI);
      i_mstatus_mie = 1'b1;
      cyc("prio mei", 1'b1, 4'd11, MIP_MEI | MIP_MTI | MIP_MSI);
      i_irq_ack = 1'b1; i_ext_irq = 1'b0;
      cyc("prio ack", 1'b0, 4'd11, MIP_MEI | MIP_MTI | MIP_MSI);
      i_irq_ack = 1'b0;
      cyc("prio wait", 1'b0, 4'd11, MIP_MTI | MIP_MSI);
      cyc("prio msi", 1'b1, 4'd3, MIP_MTI | MIP_MSI);

      // msip cleared while requesting: withdrawal, then MTI wins arbitration.
      i_msip_wen = 1'b1; i_msip_val = 1'b0;
      cyc("msip clr", 1'b1, 4'd3, MIP_MTI);
      i_msip_wen = 1'b0;
      cyc("withdraw", 1'b0, 4'd3, MIP_MTI);
      cyc("mti rearb", 1'b1, 4'd7, MIP_MTI);
      i_ext_irq = 1'b1;
      cyc("hold1", 1'b1, 4'd7, MIP_MTI);
      cyc("hold2", 1'b1, 4'd7, MIP_MEI | MIP_MTI);
      cyc("hold3", 1'b1, 4'd7, MIP_MEI | MIP_MTI);

      // Reset while requesting.
      rst = 1'b1; i_ext_irq = 1'b0; i_mie = '0; i_mstatus_mie = 1'b0; i_mode = 2'd0;
      cyc("rst in req", 1'b0, 4'd0, 64'd0);
      rst = 1'b0;
      check64("rst mtime", o_mtime, 64'd0);

      // mtime wrap from all-ones.
      force dut.mtime_q = 64'hFFFF_FFFF_FFFF_FFFF;
      #2;
      release dut.mtime_q;
      #1;
      check64("mtime preload", o_mtime, 64'hFFFF_FFFF_FFFF_FFFF);
      i_timer_tick = 1'b1;
      cyc("wrap", 1'b0, 4'd0, MIP_MTI);
      check64("mtime wrap", o_mtime, 64'd0);
      i_timer_tick = 1'b0;
      cyc("after wrap", 1'b0, 4'd0, 64'd0);
      check64("mtime hold", o_mtime, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 SHALL have port clk  input  1  core clock.
REQ-002 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-003 SHALL have port i_ext_irq  input  1  asynchronous external interrupt line.
REQ-004 SHALL have port i_timer_tick  input  1  mtime increment strobe.
REQ-005 SHALL have port i_cmp_wen  input  1  mtimecmp write enable.
REQ-006 SHALL have port i_cmp_val  input  64  mtimecmp write data.
REQ-007 SHALL have port i_msip_wen  input  1  msip write enable.
REQ-008 SHALL have port i_msip_val  input  1  msip write data.
REQ-009 SHALL have port i_mode  input  2  current privilege mode from the privilege controller.
REQ-010 SHALL have port i_mstatus_mie  input  1  global M interrupt enable.
REQ-011 SHALL have port i_mie  input  64  mie CSR value.
REQ-012 SHALL have port o_mip  output  64  live mip value (MEIP bit11, MTIP bit7, MSIP bit3; others 0).
REQ-013 SHALL have port o_mtime  output  64  current mtime.
REQ-014 SHALL have port o_irq_req  output  1  interrupt trap request to commit.
REQ-015 SHALL have port o_irq_cause  output  64  mcause value for the request.
REQ-016 SHALL have port i_irq_ack  input  1  commit accepted the request this cycle.

Function
REQ-017 SHALL synchronise i_ext_irq through 2 flops; MEIP = synchronised value (latency 2 cycles).
REQ-018 SHALL increment 64-bit mtime by 1 per cycle with i_timer_tick=1, wrapping 0xFFFF_FFFF_FFFF_FFFF -> 0.
REQ-019 SHALL write mtimecmp on i_cmp_wen; MTIP = registered (mtime >= mtimecmp), unsigned, 1-cycle latency.
REQ-020 SHALL write msip on i_msip_wen; MSIP = msip register.
REQ-021 SHALL compute candidate = o_mip & i_mie; global_en = (i_mode < M) | i_mstatus_mie.
REQ-022 SHALL select fixed priority MEI(11) > MSI(3) > MTI(7).
REQ-023 SHALL form cause = {1'b1, 59'b0, 4-bit code}.
REQ-024 SHALL implement FSM IDLE, REQ, WAIT.
REQ-025 IDLE: if candidate!=0 and global_en, latch code, go REQ next cycle.
REQ-026 REQ: o_irq_req=1, o_irq_cause fixed at latched value (no re-arbitration while requesting).
REQ-027 REQ: i_irq_ack=1 -> WAIT; ack takes precedence over withdrawal in the same cycle.
REQ-028 REQ: without ack, if latched source clears in candidate or global_en drops -> IDLE (withdraw), o_irq_req low next cycle.
REQ-029 WAIT: exactly 1 cycle (privilege controller clears mstatus.mie), then IDLE; no request raised in WAIT.
REQ-030 i_irq_ack outside REQ SHALL be ignored.
REQ-031 Simultaneous i_cmp_wen and compare SHALL use the old mtimecmp for that cycle's MTIP evaluation.

Reset
REQ-032 On rst: state=IDLE, o_irq_req=0, o_irq_cause=0, mtime=0, mtimecmp=all-ones, msip=0, sync flops=0, o_mip=0.
REQ-033 rst mid-REQ SHALL drop o_irq_req the following cycle with no ack required.

Structure
REQ-034 Interrupt codes, mip bit positions, FSM state enum, MODE_M SHALL live in the shared backend package/define header.
REQ-035 One sub-module SHALL be natural: irq_prio_enc (fixed-priority encoder, pure combinational).

Verification
REQ-036 i_ext_irq 0->1, i_mie[11]=1, i_mstatus_mie=1, i_mode=M -> o_mip[11]=1 after 2 cycles, o_irq_req=1 one cycle later, cause=0x8000_0000_0000_000B.
REQ-037 mtimecmp=5, 5 ticks, i_mie[7]=1, i_mode=U, i_mstatus_mie=0 -> MTIP=1, request cause=0x8000_0000_0000_0007.
REQ-038 MSIP, MTIP, MEIP all pending, all enabled -> cause 0xB; ack; after WAIT, with MEIP cleared -> cause 0x3.
REQ-039 In REQ, msip written 0 before ack -> o_irq_req drops next cycle, state IDLE, no ack needed.
REQ-040 i_mode=M, i_mstatus_mie=0, MEIP pending -> o_irq_req stays 0; set i_mstatus_mie=1 -> request within 2 cycles.
REQ-041 mtime preloaded to all-ones via ticks model, one tick -> o_mtime=0; rst during REQ -> o_irq_req=0 next cycle.
